// File: rtl/instruction_memory.sv
// Instruction memory: 1-cycle registered fetch read plus a handshaked burst-load port that stalls fetch.
// Optional per-word even parity is enabled by defining IMEM_PARITY_EN.
module instruction_memory #(
  parameter int DEPTH = 4096
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [19:0] instruction_rd1,
  output logic [15:0] instruction_rd1_out,
  output logic        imem_stall,
  input  logic        load_start,
  input  logic [19:0] load_address,
  input  logic [15:0] load_length,
  input  logic [15:0] load_data,
  input  logic        load_valid,
  output logic        load_ready,
  output logic        load_done,
  output logic        load_error,
  output logic        parity_error
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
`ifdef IMEM_PARITY_EN
  localparam int MW = 17;
`else
  localparam int MW = 16;
`endif

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  state_e        state_q, state_d;
  logic [19:0]   addr_ptr_q, addr_ptr_d;
  logic [15:0]   remaining_q, remaining_d;
  logic          load_error_q, load_error_d;
  logic [15:0]   rd_data_q, rd_data_d;
  logic          parity_err_d;

  logic [MW-1:0] mem [DEPTH];
  logic [MW-1:0] rd_word;
  logic [MW-1:0] mem_wdata;
  logic          mem_we;
  logic          rd_in_range;
  logic          wr_in_range;

  // Widen by one bit so DEPTH = 2**20 still compares correctly.
  assign rd_in_range = ({1'b0, instruction_rd1} < 21'(DEPTH));
  assign wr_in_range = ({1'b0, addr_ptr_q} < 21'(DEPTH));
  assign rd_word     = mem[instruction_rd1[AW-1:0]];

`ifdef IMEM_PARITY_EN
  assign mem_wdata = {^load_data, load_data};
`else
  assign mem_wdata = load_data;
`endif

  always_comb begin
    state_d      = state_q;
    addr_ptr_d   = addr_ptr_q;
    remaining_d  = remaining_q;
    load_error_d = load_error_q;
    mem_we       = 1'b0;
    rd_data_d    = 16'h0000;
    parity_err_d = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (rd_in_range) begin
          rd_data_d = rd_word[15:0];
`ifdef IMEM_PARITY_EN
          parity_err_d = rd_word[16] ^ (^rd_word[15:0]);
`endif
        end
        if (load_start) begin
          addr_ptr_d   = load_address;
          remaining_d  = load_length;
          load_error_d = 1'b0;
          state_d      = (load_length == 16'd0) ? ST_DONE : ST_LOAD;
        end
      end

      ST_LOAD: begin
        if (load_valid) begin
          if (wr_in_range) begin
            mem_we = 1'b1;
          end else begin
            load_error_d = 1'b1;
          end
          addr_ptr_d  = addr_ptr_q + 20'd1;
          remaining_d = remaining_q - 16'd1;
          if (remaining_q == 16'd1) begin
            state_d = ST_DONE;
          end
        end
      end

      ST_DONE: state_d = ST_IDLE;

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      addr_ptr_q   <= 20'd0;
      remaining_q  <= 16'd0;
      load_error_q <= 1'b0;
      rd_data_q    <= 16'h0000;
    end else begin
      state_q      <= state_d;
      addr_ptr_q   <= addr_ptr_d;
      remaining_q  <= remaining_d;
      load_error_q <= load_error_d;
      rd_data_q    <= rd_data_d;
    end
  end

  // Array deliberately has no reset; unwritten words stay X.
  always_ff @(posedge clock) begin
    if (mem_we) begin
      mem[addr_ptr_q[AW-1:0]] <= mem_wdata;
    end
  end

`ifdef IMEM_PARITY_EN
  logic parity_err_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      parity_err_q <= 1'b0;
    end else begin
      parity_err_q <= parity_err_d;
    end
  end

  assign parity_error = parity_err_q;
`else
  assign parity_error = 1'b0;
`endif

  assign instruction_rd1_out = rd_data_q;
  assign imem_stall          = (state_q != ST_IDLE);
  assign load_ready          = (state_q == ST_LOAD);
  assign load_done           = (state_q == ST_DONE);
  assign load_error          = load_error_q;

endmodule

// File: tb/tb_instruction_memory.sv
// Directed self-checking bench for instruction_memory (parity checks active when IMEM_PARITY_EN is defined).
module tb_instruction_memory;

  logic        clock;
  logic        reset;
  logic [19:0] instruction_rd1;
  logic [15:0] instruction_rd1_out;
  logic        imem_stall;
  logic        load_start;
  logic [19:0] load_address;
  logic [15:0] load_length;
  logic [15:0] load_data;
  logic        load_valid;
  logic        load_ready;
  logic        load_done;
  logic        load_error;
  logic        parity_error;

  int vectors;
  int miscompares;

  instruction_memory #(.DEPTH(4096)) dut (
    .clock               (clock),
    .reset               (reset),
    .instruction_rd1     (instruction_rd1),
    .instruction_rd1_out (instruction_rd1_out),
    .imem_stall          (imem_stall),
    .load_start          (load_start),
    .load_address        (load_address),
    .load_length         (load_length),
    .load_data           (load_data),
    .load_valid          (load_valid),
    .load_ready          (load_ready),
    .load_done           (load_done),
    .load_error          (load_error),
    .parity_error        (parity_error)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    vectors         = 0;
    miscompares     = 0;
    reset           = 1'b1;
    instruction_rd1 = 20'd5;
    load_start      = 1'b0;
    load_address    = 20'd0;
    load_length     = 16'd0;
    load_data       = 16'd0;
    load_valid      = 1'b0;

    // Reset values
    #3;
    chk("rst_rd_out", 32'(instruction_rd1_out), 32'h0);
    chk("rst_stall", 32'(imem_stall), 32'h0);
    chk("rst_ready", 32'(load_ready), 32'h0);
    chk("rst_done", 32'(load_done), 32'h0);
    chk("rst_error", 32'(load_error), 32'h0);
    chk("rst_parity", 32'(parity_error), 32'h0);
    tick();
    tick();
    reset = 1'b0;
    chk("post_rst_rd_out", 32'(instruction_rd1_out), 32'h0);
    chk("post_rst_stall", 32'(imem_stall), 32'h0);

    // Burst of 3 at 0x10, valid held high; fetch address held at 0x10 during the load
    instruction_rd1 = 20'h10;
    load_start   = 1'b1;
    load_address = 20'h10;
    load_length  = 16'd3;
    load_valid   = 1'b1;
    load_data    = 16'hA001;
    tick();
    load_start = 1'b0;
    chk("b3_c1_stall", 32'(imem_stall), 32'h1);
    chk("b3_c1_ready", 32'(load_ready), 32'h1);
    chk("b3_c1_done", 32'(load_done), 32'h0);
    tick();
    load_data = 16'hB002;
    chk("b3_c2_stall", 32'(imem_stall), 32'h1);
    chk("b3_c2_rd_nop", 32'(instruction_rd1_out), 32'h0);
    tick();
    load_data = 16'hC003;
    chk("b3_c3_stall", 32'(imem_stall), 32'h1);
    chk("b3_c3_done", 32'(load_done), 32'h0);
    tick();
    load_valid = 1'b0;
    chk("b3_c4_stall", 32'(imem_stall), 32'h1);
    chk("b3_c4_done", 32'(load_done), 32'h1);
    chk("b3_c4_ready", 32'(load_ready), 32'h0);
    chk("b3_c4_rd_nop", 32'(instruction_rd1_out), 32'h0);
    chk("b3_c4_error", 32'(load_error), 32'h0);
    tick();
    chk("b3_idle_stall", 32'(imem_stall), 32'h0);
    chk("b3_idle_done", 32'(load_done), 32'h0);

    // Back-to-back reads
    instruction_rd1 = 20'h10;
    tick();
    chk("rd_0x10", 32'(instruction_rd1_out), 32'hA001);
    instruction_rd1 = 20'h11;
    tick();
    chk("rd_0x11", 32'(instruction_rd1_out), 32'hB002);
    instruction_rd1 = 20'h12;
    tick();
    chk("rd_0x12", 32'(instruction_rd1_out), 32'hC003);
    instruction_rd1 = 20'h1000;
    tick();
    chk("rd_oor_depth", 32'(instruction_rd1_out), 32'h0);
    instruction_rd1 = 20'hFFFFF;
    tick();
    chk("rd_oor_max", 32'(instruction_rd1_out), 32'h0);

    // Burst straddling the top of memory: first word stored, second discarded
    load_start   = 1'b1;
    load_address = 20'hFFF;
    load_length  = 16'd2;
    load_valid   = 1'b1;
    load_data    = 16'h1234;
    tick();
    load_start = 1'b0;
    tick();
    load_data = 16'h5678;
    chk("edge_err_mid", 32'(load_error), 32'h0);
    tick();
    load_valid = 1'b0;
    chk("edge_done", 32'(load_done), 32'h1);
    chk("edge_err_set", 32'(load_error), 32'h1);
    tick();
    chk("edge_err_sticky", 32'(load_error), 32'h1);
    instruction_rd1 = 20'hFFF;
    tick();
    chk("rd_0xfff", 32'(instruction_rd1_out), 32'h1234);

    // Zero-length burst at 0x10 with valid data present: no write, error cleared
    load_start   = 1'b1;
    load_address = 20'h10;
    load_length  = 16'd0;
    load_valid   = 1'b1;
    load_data    = 16'hFFFF;
    tick();
    load_start = 1'b0;
    chk("zl_done", 32'(load_done), 32'h1);
    chk("zl_stall", 32'(imem_stall), 32'h1);
    chk("zl_ready", 32'(load_ready), 32'h0);
    chk("zl_err_clr", 32'(load_error), 32'h0);
    tick();
    load_valid = 1'b0;
    chk("zl_idle_stall", 32'(imem_stall), 32'h0);
    chk("zl_idle_done", 32'(load_done), 32'h0);
    instruction_rd1 = 20'h10;
    tick();
    chk("zl_no_write", 32'(instruction_rd1_out), 32'hA001);

    // Address pointer wraps 0xFFFFF -> 0: first word discarded, second lands at 0
    load_start   = 1'b1;
    load_address = 20'hFFFFF;
    load_length  = 16'd2;
    load_valid   = 1'b1;
    load_data    = 16'hDEAD;
    tick();
    load_start = 1'b0;
    tick();
    load_data = 16'h0BEE;
    tick();
    load_valid = 1'b0;
    chk("wrap_err", 32'(load_error), 32'h1);
    tick();
    instruction_rd1 = 20'h0;
    tick();
    chk("wrap_rd_0", 32'(instruction_rd1_out), 32'h0BEE);

    // Length 4, valid toggling, ignored mid-burst start, reset after 2nd handshake
    load_start   = 1'b1;
    load_address = 20'h30;
    load_length  = 16'd4;
    load_valid   = 1'b0;
    tick();
    load_start = 1'b0;
    load_valid = 1'b1;
    load_data  = 16'h1111;
    tick();
    load_valid   = 1'b0;
    load_start   = 1'b1;
    load_address = 20'h200;
    load_length  = 16'd1;
    tick();
    load_start = 1'b0;
    chk("tog_hold_stall", 32'(imem_stall), 32'h1);
    chk("tog_hold_ready", 32'(load_ready), 32'h1);
    chk("tog_hold_done", 32'(load_done), 32'h0);
    load_valid = 1'b1;
    load_data  = 16'h2222;
    tick();
    load_valid = 1'b0;
    chk("tog_pre_rst_stall", 32'(imem_stall), 32'h1);
    reset = 1'b1;
    #1;
    chk("tog_rst_stall", 32'(imem_stall), 32'h0);
    chk("tog_rst_ready", 32'(load_ready), 32'h0);
    chk("tog_rst_done", 32'(load_done), 32'h0);
    tick();
    reset = 1'b0;
    chk("tog_after_done", 32'(load_done), 32'h0);
    instruction_rd1 = 20'h30;
    tick();
    chk("tog_rd_0x30", 32'(instruction_rd1_out), 32'h1111);
    instruction_rd1 = 20'h31;
    tick();
    chk("tog_rd_0x31", 32'(instruction_rd1_out), 32'h2222);
    chk("tog_rd_parity", 32'(parity_error), 32'h0);

`ifdef IMEM_PARITY_EN
    load_start   = 1'b1;
    load_address = 20'h40;
    load_length  = 16'd1;
    load_valid   = 1'b1;
    load_data    = 16'h0001;
    tick();
    load_start = 1'b0;
    tick();
    load_valid = 1'b0;
    tick();
    dut.mem[12'h40][16] = 1'b0;
    instruction_rd1 = 20'h40;
    tick();
    chk("par_bad_data", 32'(instruction_rd1_out), 32'h0001);
    chk("par_bad_flag", 32'(parity_error), 32'h1);
    instruction_rd1 = 20'h11;
    tick();
    chk("par_good_data", 32'(instruction_rd1_out), 32'hB002);
    chk("par_good_flag", 32'(parity_error), 32'h0);
    instruction_rd1 = 20'h2000;
    tick();
    chk("par_oor_flag", 32'(parity_error), 32'h0);
`else
    instruction_rd1 = 20'h12;
    tick();
    chk("nopar_data", 32'(instruction_rd1_out), 32'hC003);
    chk("nopar_flag", 32'(parity_error), 32'h0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
